// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction classes, opcode/funct values and datapath select codes.
package mc_ctrl_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned ALU_CODE_W = 5;
    localparam int unsigned NPC_CODE_W = 3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXCPT  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_R_ALU   = 4'd1,
        C_I_ALU   = 4'd2,
        C_LW      = 4'd3,
        C_SW      = 4'd4,
        C_BEQ     = 4'd5,
        C_BNE     = 4'd6,
        C_JR      = 4'd7,
        C_J       = 4'd8,
        C_JAL     = 4'd9
    } class_e;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // Funct codes (IR[5:0]) for R-type
    localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
    localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
    localparam logic [OP_W-1:0] FN_SLLV = 6'h04;
    localparam logic [OP_W-1:0] FN_SRLV = 6'h06;
    localparam logic [OP_W-1:0] FN_SRAV = 6'h07;
    localparam logic [OP_W-1:0] FN_JR   = 6'h08;
    localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
    localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
    localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FN_AND  = 6'h24;
    localparam logic [OP_W-1:0] FN_OR   = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
    localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [OP_W-1:0] FN_SLTU = 6'h2B;

    // ALU operations
    localparam logic [ALU_CODE_W-1:0] ALU_NOP  = 5'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 5'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 5'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR  = 5'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 5'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 5'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 5'd9;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 5'd10;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 5'd11;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI  = 5'd12;
    localparam logic [ALU_CODE_W-1:0] ALU_BNE  = 5'd13;

    // Next-PC selects
    localparam logic [NPC_CODE_W-1:0] NPC_PLUS4  = 3'd0;
    localparam logic [NPC_CODE_W-1:0] NPC_BRANCH = 3'd1;
    localparam logic [NPC_CODE_W-1:0] NPC_JUMP   = 3'd2;
    localparam logic [NPC_CODE_W-1:0] NPC_JR     = 3'd3;
    localparam logic [NPC_CODE_W-1:0] NPC_EXCEPT = 3'd4;

    // Extension, destination and write-data selects
    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGNED  = 2'd1;
    localparam logic [1:0] EXT_HIGHPOS = 2'd2;
    localparam logic [1:0] GPRSEL_RD   = 2'd0;
    localparam logic [1:0] GPRSEL_RT   = 2'd1;
    localparam logic [1:0] GPRSEL_31   = 2'd2;
    localparam logic [2:0] WDSEL_ALU   = 3'd0;
    localparam logic [2:0] WDSEL_MEM   = 3'd1;
    localparam logic [2:0] WDSEL_PC    = 3'd2;

    // Decoder result: instruction class plus the ALU-side selects
    typedef struct packed {
        class_e                  cls;
        logic [ALU_CODE_W-1:0]   alu_op;
        logic                    a_sel;
        logic                    b_sel;
        logic [1:0]              ext_op;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class and ALU selects.
//  opcode, funct : IR fields
//  dec           : class + ALUOp/ASel/BSel/EXTOp (class C_ILLEGAL when undefined)
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter bit EN_BNE = 1'b1
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    output dec_t            dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.cls = C_R_ALU;
                case (funct)
                    FN_SLL:  begin dec.alu_op = ALU_SLL; dec.a_sel = 1'b1; end
                    FN_SRL:  begin dec.alu_op = ALU_SRL; dec.a_sel = 1'b1; end
                    FN_SRA:  begin dec.alu_op = ALU_SRA; dec.a_sel = 1'b1; end
                    FN_SLLV: dec.alu_op = ALU_SLL;
                    FN_SRLV: dec.alu_op = ALU_SRL;
                    FN_SRAV: dec.alu_op = ALU_SRA;
                    FN_JR:   dec.cls    = C_JR;
                    FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_NOR:  dec.alu_op = ALU_NOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLTU: dec.alu_op = ALU_SLTU;
                    default: dec.cls    = C_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec.cls = C_I_ALU; dec.alu_op = ALU_ADD; dec.b_sel = 1'b1; dec.ext_op = EXT_SIGNED;
            end
            OP_ANDI: begin dec.cls = C_I_ALU; dec.alu_op = ALU_AND; dec.b_sel = 1'b1; end
            OP_ORI:  begin dec.cls = C_I_ALU; dec.alu_op = ALU_OR;  dec.b_sel = 1'b1; end
            OP_XORI: begin dec.cls = C_I_ALU; dec.alu_op = ALU_XOR; dec.b_sel = 1'b1; end
            OP_LUI: begin
                dec.cls = C_I_ALU; dec.alu_op = ALU_LUI; dec.b_sel = 1'b1; dec.ext_op = EXT_HIGHPOS;
            end
            OP_LW, OP_SW: begin
                dec.cls    = (opcode == OP_LW) ? C_LW : C_SW;
                dec.alu_op = ALU_ADD;
                dec.b_sel  = 1'b1;
                dec.ext_op = EXT_SIGNED;
            end
            OP_BEQ: begin dec.cls = C_BEQ; dec.alu_op = ALU_SUB; end
            OP_BNE: begin
                // Without bne support the opcode falls through as illegal
                if (EN_BNE) begin
                    dec.cls = C_BNE; dec.alu_op = ALU_BNE;
                end
            end
            OP_J:    dec.cls = C_J;
            OP_JAL:  dec.cls = C_JAL;
            default: dec.cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// imem/dmem req/ack handshakes, request timeout into an exception state,
// and a retired-instruction counter.
//  clk, rst_n            : clock, async active-low reset
//  opcode, funct, Zero   : IR fields and ALU zero flag
//  stall                 : hold in FETCH before a fetch is requested
//  imem_ack, dmem_ack    : one-cycle access-done pulses
//  imem_req, dmem_req    : registered requests, held until ack or timeout
//  DMWr/IRWr/PCWr/RFWr   : datapath strobes
//  ALUOp..WDSel          : datapath selects
//  flush                 : exception flush pulse
//  state_o, retired      : debug state and retired count
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 5,
    parameter int unsigned NPCOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 32,
    parameter bit          EN_BNE      = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                Zero,
    input  logic                stall,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                DMWr,
    output logic                IRWr,
    output logic                PCWr,
    output logic                RFWr,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [NPCOP_W-1:0]  NPCOp,
    output logic                ASel,
    output logic                BSel,
    output logic [1:0]          EXTOp,
    output logic [1:0]          GPRSel,
    output logic [2:0]          WDSel,
    output logic                flush,
    output logic [2:0]          state_o,
    output logic [RETIRE_W-1:0] retired
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                imem_req_q, imem_req_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_wr_q, dmem_wr_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    dec_t                dec;

    mc_ctrl_decode #(.EN_BNE(EN_BNE)) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    // State, request and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_wr_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_wr_q  <= dmem_wr_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retired_q  <= retired_d;
        end
    end

    // Next state, request hold/drop, timeout and retire bookkeeping
    always_comb begin
        state_d    = state_q;
        imem_req_d = imem_req_q;
        dmem_req_d = dmem_req_q;
        dmem_wr_d  = dmem_wr_q;
        tmo_cnt_d  = tmo_cnt_q;
        retired_d  = retired_q;
        case (state_q)
            S_FETCH: begin
                // Request rises only when not stalled; once raised, stall no longer matters
                if (imem_req_q) begin
                    if (imem_ack) begin
                        imem_req_d = 1'b0;
                        state_d    = S_DECODE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        imem_req_d = 1'b0;
                        state_d    = S_EXCPT;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end else if (!stall) begin
                    imem_req_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (dec.cls)
                    C_J:       state_d = S_FETCH;
                    C_JAL:     state_d = S_WB;
                    C_ILLEGAL: state_d = S_EXCPT;
                    default:   state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (dec.cls)
                    C_R_ALU, C_I_ALU:     state_d = S_WB;
                    C_BEQ, C_BNE, C_JR:   state_d = S_FETCH;
                    C_LW, C_SW: begin
                        state_d    = S_MEM;
                        dmem_req_d = 1'b1;
                        dmem_wr_d  = (dec.cls == C_SW);
                        tmo_cnt_d  = '0;
                    end
                    default:              state_d = S_EXCPT;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    dmem_wr_d  = 1'b0;
                    state_d    = (dec.cls == C_LW) ? S_WB : S_FETCH;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    dmem_req_d = 1'b0;
                    dmem_wr_d  = 1'b0;
                    state_d    = S_EXCPT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_EXCPT: state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase

        if (state_d == S_FETCH && state_q != S_FETCH) begin
            tmo_cnt_d = '0;
        end
        // Every return to FETCH except from EXCPT completes an instruction
        if (state_d == S_FETCH && state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            retired_d = retired_q + RETIRE_W'(1);
        end
    end

    // Datapath strobes and selects decoded from the registered state
    always_comb begin
        IRWr   = 1'b0;
        PCWr   = 1'b0;
        RFWr   = 1'b0;
        flush  = 1'b0;
        ALUOp  = '0;
        NPCOp  = '0;
        ASel   = 1'b0;
        BSel   = 1'b0;
        EXTOp  = '0;
        GPRSel = '0;
        WDSel  = '0;
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            ALUOp = ALUOP_W'(dec.alu_op);
            ASel  = dec.a_sel;
            BSel  = dec.b_sel;
            EXTOp = dec.ext_op;
        end
        case (state_q)
            S_FETCH: begin
                if (imem_req_q && imem_ack) begin
                    IRWr  = 1'b1;
                    PCWr  = 1'b1;
                    NPCOp = NPCOP_W'(NPC_PLUS4);
                end
            end
            S_DECODE: begin
                if (dec.cls == C_J || dec.cls == C_JAL) begin
                    PCWr  = 1'b1;
                    NPCOp = NPCOP_W'(NPC_JUMP);
                end
                if (dec.cls == C_JAL) begin
                    GPRSel = GPRSEL_31;
                    WDSel  = WDSEL_PC;
                end
            end
            S_EXEC: begin
                case (dec.cls)
                    C_BEQ: begin PCWr = Zero;  NPCOp = NPCOP_W'(NPC_BRANCH); end
                    C_BNE: begin PCWr = !Zero; NPCOp = NPCOP_W'(NPC_BRANCH); end
                    C_JR:  begin PCWr = 1'b1;  NPCOp = NPCOP_W'(NPC_JR);     end
                    default: ;
                endcase
            end
            S_WB: begin
                RFWr = 1'b1;
                case (dec.cls)
                    C_I_ALU: begin GPRSel = GPRSEL_RT; WDSel = WDSEL_ALU; end
                    C_LW:    begin GPRSel = GPRSEL_RT; WDSel = WDSEL_MEM; end
                    C_JAL:   begin GPRSel = GPRSEL_31; WDSel = WDSEL_PC;  end
                    default: begin GPRSel = GPRSEL_RD; WDSel = WDSEL_ALU; end
                endcase
            end
            S_EXCPT: begin
                flush = 1'b1;
                PCWr  = 1'b1;
                NPCOp = NPCOP_W'(NPC_EXCEPT);
            end
            default: ;
        endcase
    end

    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign DMWr     = dmem_wr_q;
    assign state_o  = state_q;
    assign retired  = retired_q;

endmodule
